// File: rtl/watch_time_setter.sv
// Time editor: captures live time, edits fields with wrap and day clamp, commits via set_time strobe.
// Word packing (52 bits): {year[13:0], month[7:0], day[7:0], hour[7:0], min[7:0], sec[5:0]}; `TIMEOUT_EN adds idle auto-cancel.
module watch_time_setter #(
  parameter int TIMEOUT_SEC = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1sec,
  input  logic [51:0] cur_time,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  output logic [51:0] transfer_time,
  output logic        set_time,
  output logic        edit_active,
  output logic [2:0]  field_sel,
  output logic [51:0] edit_time
);

  localparam logic [51:0] RESET_TIME = {14'd2022, 8'd6, 8'd9, 8'd11, 8'd30, 6'd30};

  typedef enum logic {IDLE, EDIT} state_t;
  state_t state;

  logic [13:0] year;
  logic [7:0]  month, day, hour, minute;
  logic [5:0]  sec;
  assign {year, month, day, hour, minute, sec} = edit_time;

  logic        leap;
  logic [7:0]  max_date, day_fixed;
  logic [51:0] clamped_time, adjusted_time;
  logic [13:0] f_cur, f_lo, f_hi, f_new;
  logic        timeout_hit;

  function automatic logic [13:0] step(input logic [13:0] v, input logic [13:0] lo,
                                       input logic [13:0] hi, input logic up);
    if (up) step = (v >= hi) ? lo : v + 14'd1;
    else    step = (v <= lo) ? hi : v - 14'd1;
  endfunction

  always_comb begin
    leap = (((year % 14'd4) == 14'd0) && ((year % 14'd100) != 14'd0)) ||
           ((year % 14'd400) == 14'd0);
    case (month)
      8'd4, 8'd6, 8'd9, 8'd11: max_date = 8'd30;
      8'd2:                    max_date = leap ? 8'd29 : 8'd28;
      default:                 max_date = 8'd31;
    endcase
    day_fixed = (day > max_date) ? max_date : day;
  end

  // Every edit and commit works on the clamped view, so a stale day never escapes.
  assign clamped_time = {year, month, day_fixed, hour, minute, sec};

  always_comb begin
    f_cur = '0;
    f_lo  = '0;
    f_hi  = '0;
    case (field_sel)
      3'd0:    begin f_cur = year;              f_lo = 14'd1; f_hi = 14'd9999;           end
      3'd1:    begin f_cur = {6'd0, month};     f_lo = 14'd1; f_hi = 14'd12;             end
      3'd2:    begin f_cur = {6'd0, day_fixed}; f_lo = 14'd1; f_hi = {6'd0, max_date};   end
      3'd3:    begin f_cur = {6'd0, hour};      f_lo = 14'd0; f_hi = 14'd23;             end
      3'd4:    begin f_cur = {6'd0, minute};    f_lo = 14'd0; f_hi = 14'd59;             end
      default: begin f_cur = {8'd0, sec};       f_lo = 14'd0; f_hi = 14'd59;             end
    endcase
    f_new = step(f_cur, f_lo, f_hi, btn_up);
  end

  always_comb begin
    adjusted_time = clamped_time;
    case (field_sel)
      3'd0:    adjusted_time[51:38] = f_new;
      3'd1:    adjusted_time[37:30] = f_new[7:0];
      3'd2:    adjusted_time[29:22] = f_new[7:0];
      3'd3:    adjusted_time[21:14] = f_new[7:0];
      3'd4:    adjusted_time[13:6]  = f_new[7:0];
      default: adjusted_time[5:0]   = f_new[5:0];
    endcase
  end

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_SEC + 1);
  logic [CW-1:0] tick_count;
  logic          any_btn;
  assign any_btn     = btn_mode | btn_next | btn_up | btn_down | btn_cancel;
  assign timeout_hit = (state == EDIT) && clk1sec && !any_btn &&
                       (tick_count == CW'(TIMEOUT_SEC - 1));

  always_ff @(posedge clk) begin
    if (rst || state != EDIT || any_btn || timeout_hit) tick_count <= '0;
    else if (clk1sec)                                  tick_count <= tick_count + 1'b1;
  end
`else
  logic unused_ok;
  assign timeout_hit = 1'b0;
  assign unused_ok   = clk1sec | (TIMEOUT_SEC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      set_time      <= 1'b0;
      edit_active   <= 1'b0;
      field_sel     <= 3'd0;
      transfer_time <= RESET_TIME;
      edit_time     <= RESET_TIME;
    end else begin
      set_time <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_mode) begin
            edit_time   <= cur_time;
            field_sel   <= 3'd0;
            edit_active <= 1'b1;
            state       <= EDIT;
          end
        end
        default: begin
          edit_time <= clamped_time;
          if (btn_cancel || timeout_hit) begin
            edit_active <= 1'b0;
            state       <= IDLE;
          end else if (btn_mode) begin
            transfer_time <= clamped_time;
            set_time      <= 1'b1;
            edit_active   <= 1'b0;
            state         <= IDLE;
          end else if (btn_next) begin
            field_sel <= (field_sel == 3'd5) ? 3'd0 : field_sel + 3'd1;
          end else if (btn_up ^ btn_down) begin
            edit_time <= adjusted_time;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watch_time_setter.sv
// Scoreboarded bench for watch_time_setter: field-level reference model, commit queue, strobe monitor.
module tb_watch_time_setter;
  localparam int TO_SEC = 3;

  logic        clk = 1'b0, rst = 1'b1, clk1sec = 1'b0;
  logic [51:0] cur_time = '0;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic [51:0] transfer_time, edit_time;
  logic        set_time, edit_active;
  logic [2:0]  field_sel;

  watch_time_setter #(.TIMEOUT_SEC(TO_SEC)) dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec), .cur_time(cur_time),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .btn_cancel(btn_cancel), .transfer_time(transfer_time), .set_time(set_time),
    .edit_active(edit_active), .field_sel(field_sel), .edit_time(edit_time)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [51:0] exp_q[$];

  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_sel, m_tick;
  bit m_active;
  logic [51:0] m_transfer;

  function automatic logic [51:0] pack(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
    return {14'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 6'(s)};
  endfunction

  function automatic int mdays(input int y, input int mo);
    bit lp;
    lp = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    case (mo)
      4, 6, 9, 11: return 30;
      2:           return lp ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  function automatic logic [51:0] rand_time();
    int y, mo;
    y  = $urandom_range(1, 9999);
    mo = $urandom_range(1, 12);
    return pack(y, mo, $urandom_range(1, mdays(y, mo)), $urandom_range(0, 23),
                $urandom_range(0, 59), $urandom_range(0, 59));
  endfunction

  function automatic logic [51:0] model_word();
    return pack(m_y, m_mo, m_d, m_h, m_mi, m_s);
  endfunction

  task automatic model_reset();
    m_y = 2022; m_mo = 6; m_d = 9; m_h = 11; m_mi = 30; m_s = 30;
    m_sel = 0; m_tick = 0; m_active = 0;
    m_transfer = pack(2022, 6, 9, 11, 30, 30);
  endtask

  task automatic settle();
    if (m_d > mdays(m_y, m_mo)) m_d = mdays(m_y, m_mo);
  endtask

  task automatic model_adjust(input bit up);
    int md;
    md = mdays(m_y, m_mo);
    case (m_sel)
      0: m_y  = up ? (m_y % 9999) + 1 : ((m_y + 9997) % 9999) + 1;
      1: m_mo = up ? (m_mo % 12) + 1  : ((m_mo + 10) % 12) + 1;
      2: m_d  = up ? (m_d % md) + 1   : ((m_d + md - 2) % md) + 1;
      3: m_h  = up ? (m_h + 1) % 24   : (m_h + 23) % 24;
      4: m_mi = up ? (m_mi + 1) % 60  : (m_mi + 59) % 60;
      default: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
    endcase
  endtask

  task automatic model_apply(input bit m, input bit n, input bit u, input bit d,
                             input bit c, input bit sec);
    bit any_b;
    any_b = m | n | u | d | c;
    if (!m_active) begin
      if (m) begin
        m_y  = int'(cur_time[51:38]); m_mo = int'(cur_time[37:30]);
        m_d  = int'(cur_time[29:22]); m_h  = int'(cur_time[21:14]);
        m_mi = int'(cur_time[13:6]);  m_s  = int'(cur_time[5:0]);
        m_sel = 0; m_active = 1; m_tick = 0;
      end
      return;
    end
    settle();
    if (c) m_active = 0;
    else if (m) begin
      m_transfer = model_word();
      exp_q.push_back(m_transfer);
      m_active = 0;
    end else if (n) m_sel = (m_sel + 1) % 6;
    else if (u != d) model_adjust(u);
`ifdef TIMEOUT_EN
    if (any_b) m_tick = 0;
    else if (sec && m_active) begin
      m_tick++;
      if (m_tick == TO_SEC) begin m_active = 0; m_tick = 0; end
    end
`else
    if (any_b && sec) m_tick = 0;
`endif
  endtask

  task automatic check(input string name, input logic [51:0] got, input logic [51:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic press(input bit m, input bit n, input bit u, input bit d, input bit c,
                       input bit sec, input string tag);
    btn_mode = m; btn_next = n; btn_up = u; btn_down = d; btn_cancel = c; clk1sec = sec;
    model_apply(m, n, u, d, c, sec);
    @(posedge clk); #1;
    btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0; btn_cancel = 0; clk1sec = 0;
    check({tag, " edit_time"}, edit_time, model_word());
    check({tag, " edit_active"}, 52'(edit_active), 52'(m_active));
    check({tag, " field_sel"}, 52'(field_sel), 52'(m_sel));
    check({tag, " transfer_time"}, transfer_time, m_transfer);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cur_time = rand_time();
      if (m_active) settle();
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " transfer"}, transfer_time, pack(2022, 6, 9, 11, 30, 30));
    check({tag, " edit"}, edit_time, pack(2022, 6, 9, 11, 30, 30));
    check({tag, " set_time"}, 52'(set_time), 52'd0);
    check({tag, " active"}, 52'(edit_active), 52'd0);
    check({tag, " sel"}, 52'(field_sel), 52'd0);
  endtask

  initial begin
    logic [51:0] e;
    fork
      forever begin
        @(posedge clk); #2;
        if (set_time) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL strobe: set_time=1 transfer_time=%h, no commit expected", transfer_time);
          end else begin
            e = exp_q.pop_front();
            if (transfer_time !== e) begin
              miscompares++;
              $display("FAIL commit: transfer_time=%h expected %h", transfer_time, e);
            end
          end
        end
      end
    join_none

    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_reset("reset");

    // capture and plain commit
    cur_time = pack(2024, 2, 29, 23, 59, 50);
    press(1, 0, 0, 0, 0, 0, "capture");
    check("capture const", edit_time, pack(2024, 2, 29, 23, 59, 50));
    press(1, 0, 0, 0, 0, 0, "commit");
    check("commit const", transfer_time, pack(2024, 2, 29, 23, 59, 50));
    idle(2);

    // leap-day clamp after year change, then commit in the clamp cycle
    cur_time = pack(2024, 2, 29, 23, 59, 50);
    press(1, 0, 0, 0, 0, 0, "cap2");
    press(0, 0, 1, 0, 0, 0, "year up");
    idle(1);
    check("clamp const", edit_time, pack(2025, 2, 28, 23, 59, 50));
    press(1, 0, 0, 0, 0, 0, "commit2");
    check("commit2 const", transfer_time, pack(2025, 2, 28, 23, 59, 50));
    cur_time = pack(2024, 2, 29, 1, 2, 3);
    press(1, 0, 0, 0, 0, 0, "cap3");
    press(0, 0, 1, 0, 0, 0, "year up3");
    press(1, 0, 0, 0, 0, 0, "commit3");
    check("commit3 const", transfer_time, pack(2025, 2, 28, 1, 2, 3));
    idle(1);

    // wrap boundaries
    cur_time = pack(9999, 1, 31, 23, 59, 0);
    press(1, 0, 0, 0, 0, 0, "cap wrap");
    press(0, 0, 1, 0, 0, 0, "year wrap");
    press(0, 1, 0, 0, 0, 0, "next");
    press(0, 1, 0, 0, 0, 0, "next");
    press(0, 0, 1, 0, 0, 0, "day wrap");
    press(0, 1, 0, 0, 0, 0, "next");
    press(0, 0, 1, 0, 0, 0, "hour wrap");
    press(0, 1, 0, 0, 0, 0, "next");
    press(0, 1, 0, 0, 0, 0, "next");
    press(0, 0, 0, 1, 0, 0, "sec wrap");
    check("wraps const", edit_time, pack(1, 1, 1, 0, 59, 59));
    press(0, 1, 0, 0, 0, 0, "sel wrap");
    check("sel wrap const", 52'(field_sel), 52'd0);
    press(0, 1, 0, 0, 0, 0, "next");
    press(0, 0, 0, 1, 0, 0, "month wrap");
    press(0, 0, 1, 1, 0, 0, "up+down");
    check("month const", edit_time, pack(1, 12, 1, 0, 59, 59));
    press(0, 0, 0, 0, 1, 0, "cancel");
    check("cancel keeps transfer", transfer_time, pack(2025, 2, 28, 1, 2, 3));
    idle(1);
    press(1, 0, 0, 0, 0, 0, "cap4");
    press(1, 0, 0, 0, 1, 0, "mode+cancel");
    check("mode+cancel active", 52'(edit_active), 52'd0);

    // reset in the middle of an edit
    press(1, 0, 0, 0, 0, 0, "cap5");
    press(0, 0, 1, 0, 0, 0, "edit5");
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check_reset("mid-edit reset");

`ifdef TIMEOUT_EN
    idle(1);
    press(1, 0, 0, 0, 0, 0, "to cap");
    press(0, 0, 0, 0, 0, 1, "tick1");
    idle(1);
    press(0, 0, 0, 0, 0, 1, "tick2");
    press(0, 0, 0, 0, 0, 1, "tick3");
    check("timeout const", 52'(edit_active), 52'd0);
    press(1, 0, 0, 0, 0, 0, "to cap2");
    press(0, 0, 0, 0, 0, 1, "tick1b");
    press(0, 1, 0, 0, 0, 1, "btn on tick2");
    press(0, 0, 0, 0, 0, 1, "tick1c");
    press(0, 0, 0, 0, 0, 1, "tick2c");
    check("restart const", 52'(edit_active), 52'd1);
    press(0, 0, 0, 0, 0, 1, "tick3c");
    check("timeout2 const", 52'(edit_active), 52'd0);
`else
    idle(1);
    press(1, 0, 0, 0, 0, 0, "sec cap");
    for (int k = 0; k < 5; k++) press(0, 0, 0, 0, 0, 1, "sec ignored");
    check("no timeout const", 52'(edit_active), 52'd1);
    press(0, 0, 0, 0, 1, 0, "sec cancel");
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      bit s;
      r = $urandom_range(0, 99);
      s = ($urandom_range(0, 3) == 0);
      if (!m_active && $urandom_range(0, 1) == 1) press(1, 0, 0, 0, 0, s, "rnd cap");
      else if (r < 15) press(1, 0, 0, 0, 0, s, "rnd mode");
      else if (r < 35) press(0, 1, 0, 0, 0, s, "rnd next");
      else if (r < 60) press(0, 0, 1, 0, 0, s, "rnd up");
      else if (r < 85) press(0, 0, 0, 1, 0, s, "rnd down");
      else if (r < 90) press(0, 0, 0, 0, 1, s, "rnd cancel");
      else if (r < 95) press(0, 0, 1, 1, 0, s, "rnd up+down");
      else if (r < 98) press(1, 0, 0, 0, 1, s, "rnd mode+cancel");
      else press(0, 0, 0, 0, 0, s, "rnd none");
      idle($urandom_range(0, 2));
    end

    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL commit queue: %0d commits never strobed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
